tilelink_master_top: RTL and testbench

TileLink Uncached-Lightweight (TL-UL) master adapter with one transaction in flight. It accepts single-cycle request pulses from a local client and issues them on the TL A channel. It then waits for the matching D-channel response and reports it back to the client. It sits between a core-side request generator and a TL-UL slave or crossbar port.

---
 rtl/tilelink_master_top.sv | 182 ++++++++++++++++++
 tb/tb_tilelink_master_top.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilelink_master_top.sv
// tilelink_master_top
//
// TL-UL master adapter with a single outstanding transaction. A one-cycle
// client request is either passed straight onto the A channel (when the slave
// is ready in the same cycle) or held in request registers until the slave
// accepts it. The adapter then waits for one D beat, captures it and reports
// it back to the client as a one-cycle response pulse.
//
// Ports
//   clk, rst                clock, synchronous active-high reset
//   a_valid_in, a_*_in      client request strobe and fields
//   a_valid, a_ready, a_*   TL A channel (master side)
//   d_valid, d_ready, d_*   TL D channel (master side)
//   busy                    high whenever a transaction is in flight
//   resp_valid              one-cycle pulse after a D beat is accepted
//   resp_opcode/data/error  captured D opcode, data and error status

module tilelink_master_top #(
    parameter int unsigned TL_ADDR_WIDTH   = 64,
    parameter int unsigned TL_DATA_WIDTH   = 64,
    parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int unsigned TL_SOURCE_WIDTH = 3,
    parameter int unsigned TL_SINK_WIDTH   = 3,
    parameter int unsigned TL_OPCODE_WIDTH = 3,
    parameter int unsigned TL_PARAM_WIDTH  = 3,
    parameter int unsigned TL_SIZE_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,

    // Client request
    input  logic                       a_valid_in,
    input  logic [TL_OPCODE_WIDTH-1:0] a_opcode_in,
    input  logic [TL_PARAM_WIDTH-1:0]  a_param_in,
    input  logic [TL_ADDR_WIDTH-1:0]   a_address_in,
    input  logic [TL_SIZE_WIDTH-1:0]   a_size_in,
    input  logic [TL_STRB_WIDTH-1:0]   a_mask_in,
    input  logic [TL_DATA_WIDTH-1:0]   a_data_in,
    input  logic [TL_SOURCE_WIDTH-1:0] a_source_in,

    // TL A channel
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]  a_param,
    output logic [TL_ADDR_WIDTH-1:0]   a_address,
    output logic [TL_SIZE_WIDTH-1:0]   a_size,
    output logic [TL_STRB_WIDTH-1:0]   a_mask,
    output logic [TL_DATA_WIDTH-1:0]   a_data,
    output logic [TL_SOURCE_WIDTH-1:0] a_source,

    // TL D channel
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]  d_param,
    input  logic [TL_SIZE_WIDTH-1:0]   d_size,
    input  logic [TL_SINK_WIDTH-1:0]   d_sink,
    input  logic [TL_SOURCE_WIDTH-1:0] d_source,
    input  logic [TL_DATA_WIDTH-1:0]   d_data,
    input  logic                       d_error,

    // Client response
    output logic                       busy,
    output logic                       resp_valid,
    output logic [TL_OPCODE_WIDTH-1:0] resp_opcode,
    output logic [TL_DATA_WIDTH-1:0]   resp_data,
    output logic                       resp_error
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSendA = 2'd1,
        StWaitD = 2'd2
    } state_e;

    state_e                     state_q;

    logic [TL_OPCODE_WIDTH-1:0] req_opcode_q;
    logic [TL_PARAM_WIDTH-1:0]  req_param_q;
    logic [TL_ADDR_WIDTH-1:0]   req_address_q;
    logic [TL_SIZE_WIDTH-1:0]   req_size_q;
    logic [TL_STRB_WIDTH-1:0]   req_mask_q;
    logic [TL_DATA_WIDTH-1:0]   req_data_q;
    logic [TL_SOURCE_WIDTH-1:0] req_source_q;

    logic                       resp_valid_q;
    logic [TL_OPCODE_WIDTH-1:0] resp_opcode_q;
    logic [TL_DATA_WIDTH-1:0]   resp_data_q;
    logic                       resp_error_q;

    // D-channel fields the client does not need.
    logic unused_d_fields;
    assign unused_d_fields = ^{d_param, d_size, d_sink};

    // State, request registers and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_opcode_q  <= '0;
            req_param_q   <= '0;
            req_address_q <= '0;
            req_size_q    <= '0;
            req_mask_q    <= '0;
            req_data_q    <= '0;
            req_source_q  <= '0;
            resp_valid_q  <= 1'b0;
            resp_opcode_q <= '0;
            resp_data_q   <= '0;
            resp_error_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (a_valid_in) begin
                        req_opcode_q  <= a_opcode_in;
                        req_param_q   <= a_param_in;
                        req_address_q <= a_address_in;
                        req_size_q    <= a_size_in;
                        req_mask_q    <= a_mask_in;
                        req_data_q    <= a_data_in;
                        req_source_q  <= a_source_in;
                        // Same-cycle handshake skips the SEND_A hold state.
                        state_q       <= a_ready ? StWaitD : StSendA;
                    end
                end
                StSendA: begin
                    if (a_ready) begin
                        state_q <= StWaitD;
                    end
                end
                StWaitD: begin
                    if (d_valid) begin
                        resp_valid_q  <= 1'b1;
                        resp_opcode_q <= d_opcode;
                        resp_data_q   <= d_data;
                        // A response routed to the wrong source is reported as an error.
                        resp_error_q  <= d_error | (d_source != req_source_q);
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Channel handshakes and A fields decoded from the current state.
    always_comb begin
        a_valid   = 1'b0;
        d_ready   = 1'b0;
        a_opcode  = req_opcode_q;
        a_param   = req_param_q;
        a_address = req_address_q;
        a_size    = req_size_q;
        a_mask    = req_mask_q;
        a_data    = req_data_q;
        a_source  = req_source_q;
        unique case (state_q)
            StIdle: begin
                // Zero-latency bypass of the client request onto A.
                a_valid   = a_valid_in & ~rst;
                a_opcode  = a_opcode_in;
                a_param   = a_param_in;
                a_address = a_address_in;
                a_size    = a_size_in;
                a_mask    = a_mask_in;
                a_data    = a_data_in;
                a_source  = a_source_in;
            end
            StSendA: a_valid = 1'b1;
            StWaitD: d_ready = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign resp_valid  = resp_valid_q;
    assign resp_opcode = resp_opcode_q;
    assign resp_data   = resp_data_q;
    assign resp_error  = resp_error_q;

endmodule

// File: tb/tb_tilelink_master_top.sv
// Directed bench for tilelink_master_top. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 time unit later, well away from the edge.

module tb_tilelink_master_top;

    localparam logic [2:0] PutFullDataA   = 3'd0;
    localparam logic [2:0] GetA           = 3'd4;
    localparam logic [2:0] AccessAckD     = 3'd0;
    localparam logic [2:0] AccessAckDataD = 3'd1;

    logic        clk;
    logic        rst;
    logic        a_valid_in;
    logic [2:0]  a_opcode_in;
    logic [2:0]  a_param_in;
    logic [63:0] a_address_in;
    logic [7:0]  a_size_in;
    logic [7:0]  a_mask_in;
    logic [63:0] a_data_in;
    logic [2:0]  a_source_in;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [63:0] a_address;
    logic [7:0]  a_size;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic [2:0]  a_source;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [7:0]  d_size;
    logic [2:0]  d_sink;
    logic [2:0]  d_source;
    logic [63:0] d_data;
    logic        d_error;
    logic        busy;
    logic        resp_valid;
    logic [2:0]  resp_opcode;
    logic [63:0] resp_data;
    logic        resp_error;

    int n_checks = 0;
    int n_fails  = 0;

    tilelink_master_top dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid_in   (a_valid_in),
        .a_opcode_in  (a_opcode_in),
        .a_param_in   (a_param_in),
        .a_address_in (a_address_in),
        .a_size_in    (a_size_in),
        .a_mask_in    (a_mask_in),
        .a_data_in    (a_data_in),
        .a_source_in  (a_source_in),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_param      (a_param),
        .a_address    (a_address),
        .a_size       (a_size),
        .a_mask       (a_mask),
        .a_data       (a_data),
        .a_source     (a_source),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_opcode     (d_opcode),
        .d_param      (d_param),
        .d_size       (d_size),
        .d_sink       (d_sink),
        .d_source     (d_source),
        .d_data       (d_data),
        .d_error      (d_error),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_opcode  (resp_opcode),
        .resp_data    (resp_data),
        .resp_error   (resp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] size,
                             input logic [7:0] mask, input logic [63:0] data,
                             input logic [2:0] src);
        a_valid_in   = 1'b1;
        a_opcode_in  = op;
        a_param_in   = 3'd0;
        a_address_in = addr;
        a_size_in    = size;
        a_mask_in    = mask;
        a_data_in    = data;
        a_source_in  = src;
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [63:0] data, input logic [2:0] src,
                           input logic err);
        d_valid  = 1'b1;
        d_opcode = op;
        d_data   = data;
        d_source = src;
        d_error  = err;
    endtask

    initial begin
        rst          = 1'b1;
        a_valid_in   = 1'b1;  // must be masked while in reset
        a_opcode_in  = GetA;
        a_param_in   = '0;
        a_address_in = 64'h55;
        a_size_in    = '0;
        a_mask_in    = '0;
        a_data_in    = '0;
        a_source_in  = '0;
        a_ready      = 1'b1;
        d_valid      = 1'b0;
        d_opcode     = '0;
        d_param      = '0;
        d_size       = '0;
        d_sink       = '0;
        d_source     = '0;
        d_data       = '0;
        d_error      = 1'b0;

        // Reset state
        tick();
        tick();
        settle();
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_d_ready", d_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_opcode", resp_opcode, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_error", resp_error, 0);
        a_valid_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        settle();
        check_eq("post_rst_busy", busy, 0);

        // Write with same-cycle handshake
        drive_req(PutFullDataA, 64'h1000_0000, 8'd3, 8'hFF, 64'hDEADBEEFCAFEBABE, 3'd1);
        settle();
        check_eq("wr_a_valid", a_valid, 1);
        check_eq("wr_a_opcode", a_opcode, PutFullDataA);
        check_eq("wr_a_address", a_address, 64'h1000_0000);
        check_eq("wr_a_size", a_size, 3);
        check_eq("wr_a_mask", a_mask, 8'hFF);
        check_eq("wr_a_data", a_data, 64'hDEADBEEFCAFEBABE);
        check_eq("wr_a_source", a_source, 1);
        check_eq("wr_idle_d_ready", d_ready, 0);
        tick();
        a_valid_in = 1'b0;
        settle();
        check_eq("wr_wait_d_ready", d_ready, 1);
        check_eq("wr_wait_a_valid", a_valid, 0);
        check_eq("wr_wait_busy", busy, 1);
        tick();
        drive_d(AccessAckD, 64'h0, 3'd1, 1'b0);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("wr_resp_valid", resp_valid, 1);
        check_eq("wr_resp_opcode", resp_opcode, AccessAckD);
        check_eq("wr_resp_error", resp_error, 0);
        check_eq("wr_done_busy", busy, 0);
        check_eq("wr_done_d_ready", d_ready, 0);
        tick();
        settle();
        check_eq("wr_resp_pulse_end", resp_valid, 0);

        // Read with immediate response
        drive_req(GetA, 64'h2000_0040, 8'd3, 8'hFF, 64'h0, 3'd2);
        tick();
        a_valid_in = 1'b0;
        drive_d(AccessAckDataD, 64'hBEEFDEADBEEFDEAD, 3'd2, 1'b0);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("rd_resp_valid", resp_valid, 1);
        check_eq("rd_resp_data", resp_data, 64'hBEEFDEADBEEFDEAD);
        check_eq("rd_resp_opcode", resp_opcode, AccessAckDataD);
        check_eq("rd_resp_error", resp_error, 0);

        // Back-to-back GETs, one every two cycles
        for (int i = 0; i < 3; i++) begin
            drive_req(GetA, 64'h3000_0000 + 64'(i * 8), 8'd3, 8'hFF, 64'h0, 3'(i + 4));
            settle();
            check_eq($sformatf("b2b%0d_a_valid", i), a_valid, 1);
            check_eq($sformatf("b2b%0d_a_address", i), a_address, 64'h3000_0000 + 64'(i * 8));
            tick();
            a_valid_in = 1'b0;
            drive_d(AccessAckDataD, 64'hA5A5_0000 + 64'(i), 3'(i + 4), 1'b0);
            tick();
            d_valid = 1'b0;
            settle();
            check_eq($sformatf("b2b%0d_resp_valid", i), resp_valid, 1);
            check_eq($sformatf("b2b%0d_resp_data", i), resp_data, 64'hA5A5_0000 + 64'(i));
            check_eq($sformatf("b2b%0d_busy", i), busy, 0);
            #1;  // back to the drive point of this cycle
        end

        // Backpressure: a_ready low for three cycles
        tick();
        a_ready = 1'b0;
        drive_req(GetA, 64'h4000_1230, 8'd2, 8'h0F, 64'h0, 3'd5);
        settle();
        check_eq("bp_idle_a_valid", a_valid, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            // Client fields change; A must keep the captured request.
            drive_req(PutFullDataA, 64'hFFFF_0000, 8'd0, 8'h00, 64'h1, 3'd7);
            settle();
            check_eq($sformatf("bp%0d_a_valid", i), a_valid, 1);
            check_eq($sformatf("bp%0d_a_address", i), a_address, 64'h4000_1230);
            check_eq($sformatf("bp%0d_a_opcode", i), a_opcode, GetA);
            check_eq($sformatf("bp%0d_a_source", i), a_source, 5);
            check_eq($sformatf("bp%0d_busy", i), busy, 1);
            check_eq($sformatf("bp%0d_d_ready", i), d_ready, 0);
        end
        tick();
        a_valid_in = 1'b0;
        a_ready    = 1'b1;
        settle();
        check_eq("bp_hs_a_valid", a_valid, 1);
        check_eq("bp_hs_a_mask", a_mask, 8'h0F);
        tick();
        settle();
        check_eq("bp_wait_d_ready", d_ready, 1);
        check_eq("bp_wait_a_valid", a_valid, 0);
        #1;
        drive_d(AccessAckDataD, 64'h77, 3'd5, 1'b0);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("bp_resp_valid", resp_valid, 1);
        check_eq("bp_resp_data", resp_data, 64'h77);
        check_eq("bp_resp_error", resp_error, 0);

        // Stray d_valid while idle
        tick();
        drive_d(AccessAckDataD, 64'h99, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("stray%0d_d_ready", i), d_ready, 0);
            tick();
            settle();
            check_eq($sformatf("stray%0d_resp_valid", i), resp_valid, 0);
            #1;
        end

        // Source mismatch, with d_valid still held high from above
        drive_req(GetA, 64'h5000_0000, 8'd3, 8'hFF, 64'h0, 3'd2);
        d_source = 3'd3;
        settle();
        check_eq("mm_idle_d_ready", d_ready, 0);
        tick();
        a_valid_in = 1'b0;
        tick();
        settle();
        check_eq("mm_resp_valid", resp_valid, 1);
        check_eq("mm_resp_error", resp_error, 1);
        check_eq("mm_resp_data", resp_data, 64'h99);
        #1;
        tick();
        settle();
        check_eq("mm_held_dvalid_no_resp", resp_valid, 0);
        check_eq("mm_held_dvalid_d_ready", d_ready, 0);
        #1;
        d_valid = 1'b0;

        // d_error with matching source
        drive_req(GetA, 64'h5000_0008, 8'd3, 8'hFF, 64'h0, 3'd6);
        tick();
        a_valid_in = 1'b0;
        drive_d(AccessAckDataD, 64'h1234, 3'd6, 1'b1);
        tick();
        d_valid = 1'b0;
        settle();
        check_eq("derr_resp_valid", resp_valid, 1);
        check_eq("derr_resp_error", resp_error, 1);
        #1;

        // Reset while waiting for D
        drive_req(GetA, 64'h6000_0000, 8'd3, 8'hFF, 64'h0, 3'd1);
        tick();
        a_valid_in = 1'b0;
        settle();
        check_eq("rw_busy", busy, 1);
        #1;
        rst = 1'b1;
        drive_d(AccessAckDataD, 64'hBAD, 3'd1, 1'b0);
        tick();
        rst     = 1'b0;
        d_valid = 1'b0;
        settle();
        check_eq("rw_busy_after", busy, 0);
        check_eq("rw_d_ready_after", d_ready, 0);
        check_eq("rw_resp_valid_after", resp_valid, 0);
        check_eq("rw_resp_error_after", resp_error, 0);
        #1;
        tick();
        settle();
        check_eq("rw_resp_valid_later", resp_valid, 0);
        check_eq("rw_resp_data_cleared", resp_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
